// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack / normalise+round / pack), RNE rounding,
// valid/ready backpressure. Define INT_MODE_EN to add a signed half-width integer multiply path selected by mode.
module fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   underflow,
    output logic                   overflow
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;

    logic stall;

    logic                 s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic signed [EW-1:0] s1_e_q;
    logic [PW-1:0]        s1_prod_q;

    logic                 s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
    logic signed [EW-1:0] s2_e_q;
    logic [MAN_W+1:0]     s2_man_q;

    logic                 out_valid_q, underflow_q, overflow_q;
    logic [W-1:0]         result_q;

    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     ma, mb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                 s1_nan_d, s1_inf_d, s1_zero_d;
    logic signed [EW-1:0] s1_e_d;
    logic [PW-1:0]        s1_prod_d;

    logic [PW-1:0]        shifted;
    logic                 round_up;
    logic [MAN_W+1:0]     s2_man_d;
    logic signed [EW-1:0] s2_e_d;

    logic signed [EW-1:0] e_fin;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         result_d;
    logic                 underflow_d, overflow_d;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    // Unpack: classify operands (denormals count as zero) and form the exact significand product.
    assign ea     = a[W-2:MAN_W];
    assign eb     = b[W-2:MAN_W];
    assign ma     = a[MAN_W-1:0];
    assign mb     = b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (ma == '0);
    assign b_inf  = (eb == EXP_ONES) && (mb == '0);
    assign a_nan  = (ea == EXP_ONES) && (ma != '0);
    assign b_nan  = (eb == EXP_ONES) && (mb != '0);

    assign s1_nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign s1_inf_d  = (a_inf | b_inf) & ~s1_nan_d;
    assign s1_zero_d = (a_zero | b_zero) & ~s1_nan_d;
    assign s1_e_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
    assign s1_prod_d = {{(MAN_W + 1){1'b0}}, 1'b1, ma} * {{(MAN_W + 1){1'b0}}, 1'b1, mb};

    // Normalise so the hidden bit sits at the top, then round to nearest even.
    assign shifted  = s1_prod_q[PW-1] ? s1_prod_q : (s1_prod_q << 1);
    assign round_up = shifted[MAN_W] & ((|shifted[MAN_W-1:0]) | shifted[MAN_W+1]);
    assign s2_man_d = {1'b0, shifted[PW-1:MAN_W+1]} + {{(MAN_W + 1){1'b0}}, round_up};
    assign s2_e_d   = s1_e_q + $signed({{(EW - 1){1'b0}}, s1_prod_q[PW-1]});

    assign e_fin = s2_e_q + $signed({{(EW - 1){1'b0}}, s2_man_q[MAN_W+1]});
    assign frac  = s2_man_q[MAN_W+1] ? s2_man_q[MAN_W:1] : s2_man_q[MAN_W-1:0];

`ifdef INT_MODE_EN
    localparam int H = W / 2;
    logic         s1_mode_q, s2_mode_q;
    logic [W-1:0] s1_int_q, s2_int_q, int_prod_d;

    // Sign-extended W-bit operands give an exact product because the true result fits in 2*H <= W bits.
    assign int_prod_d = {{(W - H){a[H-1]}}, a[H-1:0]} * {{(W - H){b[H-1]}}, b[H-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_mode_q <= 1'b0;
            s1_int_q  <= '0;
            s2_mode_q <= 1'b0;
            s2_int_q  <= '0;
        end else if (!stall) begin
            s1_mode_q <= mode;
            s1_int_q  <= int_prod_d;
            s2_mode_q <= s1_mode_q;
            s2_int_q  <= s1_int_q;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_comb begin
        result_d    = {s2_sign_q, e_fin[EXP_W-1:0], frac};
        underflow_d = 1'b0;
        overflow_d  = 1'b0;
        if (s2_nan_q) begin
            result_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};
        end else if (s2_inf_q) begin
            result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s2_zero_q) begin
            result_d = {s2_sign_q, {(W - 1){1'b0}}};
        end else if (e_fin >= EMAX_S) begin
            result_d   = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            overflow_d = 1'b1;
        end else if (e_fin <= ZERO_S) begin
            result_d    = {s2_sign_q, {(W - 1){1'b0}}};
            underflow_d = 1'b1;
        end
`ifdef INT_MODE_EN
        if (s2_mode_q) begin
            result_d    = s2_int_q;
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_e_q      <= '0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_e_q      <= '0;
            s2_man_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (!stall) begin
            s1_valid_q  <= in_valid;
            s1_sign_q   <= a[W-1] ^ b[W-1];
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s1_zero_q   <= s1_zero_d;
            s1_e_q      <= s1_e_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_nan_q    <= s1_nan_q;
            s2_inf_q    <= s1_inf_q;
            s2_zero_q   <= s1_zero_q;
            s2_e_q      <= s2_e_d;
            s2_man_q    <= s2_man_d;
            out_valid_q <= s2_valid_q;
            result_q    <= result_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (fp16): behavioural value model + in-order scoreboard, directed literal vectors,
// randomized traffic with backpressure, and a reset-flush scenario.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        underflow;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .underflow(underflow), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Returns {underflow, overflow, result}, computed from real-number rules on integers.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic m);
        logic   s, use_int, xz, yz, xi, yi, xn, yn;
        int     ex, ey, fx, fy, e, sh, ip;
        longint p, q, rem, half;
`ifdef INT_MODE_EN
        use_int = m;
`else
        use_int = m & 1'b0;
`endif
        if (use_int) begin
            ip = $signed(x[7:0]) * $signed(y[7:0]);
            return {2'b00, ip[15:0]};
        end
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        fx = int'(x[9:0]);
        fy = int'(y[9:0]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 31) && (fx == 0);
        yi = (ey == 31) && (fy == 0);
        xn = (ex == 31) && (fx != 0);
        yn = (ey == 31) && (fy != 0);
        if (xn || yn || (xi && yz) || (yi && xz)) return {2'b00, 16'h7E00};
        if (xi || yi) return {2'b00, s, 5'h1F, 10'h000};
        if (xz || yz) return {2'b00, s, 15'h0000};
        p    = longint'(1024 + fx) * longint'(1024 + fy);
        e    = ex + ey - 15;
        sh   = (p >= 2097152) ? 11 : 10;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e = e + sh - 10;
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        if (e >= 31) return {2'b01, s, 5'h1F, 10'h000};
        if (e <= 0) return {2'b10, s, 15'h0000};
        return {2'b00, s, 5'(e), 10'(q)};
    endfunction

    function automatic logic [15:0] rnd_op();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 16'($urandom);
        if (k == 1) return {1'($urandom), ($urandom_range(0, 1) == 1) ? 5'h1F : 5'h00,
                            ($urandom_range(0, 1) == 1) ? 10'h000 : 10'($urandom)};
        return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
    endfunction

    // Scoreboard: every cycle the output is valid it must equal the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk($sformatf("stream_%0d", n_out), {14'd0, underflow, overflow, result}, {14'd0, exp_q[0]});
                    if (out_ready) begin
                        $display("out %0d result=%h uf=%b of=%b", n_out, result, underflow, overflow);
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, mode));
                n_in++;
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic run_vec(input int idx, input logic [15:0] va, input logic [15:0] vb,
                           input logic vm, input logic [17:0] req);
        int lat;
        chk($sformatf("model_%0d", idx), 32'(model(va, vb, vm)), 32'(req));
        @(posedge clk); #1;
        a = va; b = vb; mode = vm; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency_%0d", idx), lat, 3);
        chk($sformatf("result_%0d", idx), {14'd0, underflow, overflow, result}, {14'd0, req});
        @(posedge clk); #1;
    endtask

    task automatic random_phase(input int nops);
        int   sent, guard;
        logic acc;
        sent = 0;
        guard = 0;
        @(posedge clk); #1;
        a = rnd_op(); b = rnd_op(); mode = 1'($urandom_range(0, 1));
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
        while (sent < nops && guard < 20000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) sent++;
            if (acc || !in_valid) begin
                a = rnd_op(); b = rnd_op(); mode = 1'($urandom_range(0, 1));
                in_valid = (sent < nops) && ($urandom_range(0, 9) < 7);
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        chk("random_sent", sent, nops);
        drain();
    endtask

    task automatic backpressure_phase();
        int   idx, base;
        logic acc;
        idx = 0;
        base = n_out;
        @(posedge clk); #1;
        a = rnd_op(); b = rnd_op(); mode = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            out_ready = !(k >= 5 && k < 10);
            @(negedge clk);
            if (k >= 5 && k < 10) begin
                chk($sformatf("stall_in_ready_%0d", k), 32'(in_ready), 32'd0);
                chk($sformatf("stall_out_valid_%0d", k), 32'(out_valid), 32'd1);
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 10) begin
                    a = rnd_op(); b = rnd_op();
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("bp_accepted", idx, 10);
        chk("bp_emitted", n_out - base, 10);
        drain();
    endtask

    task automatic reset_phase();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            a = rnd_op(); b = 16'h3C00; mode = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_flags_result", {13'd0, underflow, overflow, result}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post_reset_idle_%0d", k), 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_state", {13'd0, underflow, overflow, result}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        run_vec(0,  16'h3C00, 16'h4000, 1'b0, {2'b00, 16'h4000});
        run_vec(1,  16'h3E00, 16'h3E00, 1'b0, {2'b00, 16'h4080});
        run_vec(2,  16'h3C01, 16'h3C01, 1'b0, {2'b00, 16'h3C02});
        run_vec(3,  16'h3C01, 16'h3BFF, 1'b0, {2'b00, 16'h3C00});
        run_vec(4,  16'hBC00, 16'h3C00, 1'b0, {2'b00, 16'hBC00});
        run_vec(5,  16'h7BFF, 16'h7BFF, 1'b0, {2'b01, 16'h7C00});
        run_vec(6,  16'h0400, 16'h0400, 1'b0, {2'b10, 16'h0000});
        run_vec(7,  16'h8400, 16'h0400, 1'b0, {2'b10, 16'h8000});
        run_vec(8,  16'h7C00, 16'h0000, 1'b0, {2'b00, 16'h7E00});
        run_vec(9,  16'h7C00, 16'hC000, 1'b0, {2'b00, 16'hFC00});
        run_vec(10, 16'h7E01, 16'h3C00, 1'b0, {2'b00, 16'h7E00});
        run_vec(11, 16'h0001, 16'h3C00, 1'b0, {2'b00, 16'h0000});
`ifdef INT_MODE_EN
        run_vec(12, 16'h00FD, 16'h0007, 1'b1, {2'b00, 16'hFFEB});
        run_vec(13, 16'h0080, 16'h0080, 1'b1, {2'b00, 16'h4000});
        run_vec(14, 16'h3C00, 16'h4000, 1'b1, {2'b00, 16'h0000});
`else
        run_vec(14, 16'h3C00, 16'h4000, 1'b1, {2'b00, 16'h4000});
`endif

        random_phase(300);
        backpressure_phase();
        reset_phase();
        drain();
        chk("in_out_balance", n_in - n_out, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
